// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and data load/store.
// Data has priority over fetch. Address and data are held on the RAM port until the
// RAM reports ACCESS, and a one-cycle hit goes back to the requester that completed.
// Optional build macro: MEM_ARBITER_STARVE_GUARD_EN adds a fetch starvation guard.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DACC = 2'b01,
    IACC = 2'b10
  } state_e;

  // Reject a counter too narrow to reach the starvation limit.
  if ((32'd1 << CNT_W) <= STARVE_LIMIT) begin : g_cfg_check
    $error("mem_arbiter: CNT_W too small for STARVE_LIMIT");
  end

  state_e state_q, state_d;
  logic   starve_force;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q == StarveMax) && iREN;

  // Count data completions that overtook a pending fetch; clear once the fetch is served.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IACC && iREN && ramstate == RAM_ACCESS) begin
      starve_cnt_d = '0;
    end else if (state_q == IDLE && !iREN) begin
      starve_cnt_d = '0;
    end else if (state_q == DACC && (dREN || dWEN) && ramstate == RAM_ACCESS
                 && iREN && starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and RAM/requester outputs; everything is zero unless a grant drives it.
  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    iload    = 32'h0;
    ihit     = 1'b0;
    dload    = 32'h0;
    dhit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (starve_force) begin
          state_d = IACC;
        end else if (dREN || dWEN) begin
          state_d = DACC;
        end else if (iREN) begin
          state_d = IACC;
        end
      end

      DACC: begin
        if (!(dREN || dWEN)) begin
          // Requester withdrew: release the RAM without a hit.
          state_d = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == RAM_ACCESS) begin
            dhit    = 1'b1;
            dload   = ramload;
            state_d = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            state_d = IDLE;
          end
        end
      end

      IACC: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RAM_ACCESS) begin
            ihit    = 1'b1;
            iload   = ramload;
            state_d = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
